// File: rtl/regarb_pkg.sv
// Register-file arbiter shared definitions: op encodings, register codes,
// and the select-to-strobe decode helpers.
package regarb_pkg;

    typedef enum logic [1:0] {
        OP_RD8  = 2'b00,
        OP_WR8  = 2'b01,
        OP_RD16 = 2'b10,
        OP_WR16 = 2'b11
    } op_e;

    localparam logic [2:0] R8_W = 3'd0;
    localparam logic [2:0] R8_Z = 3'd1;
    localparam logic [2:0] R8_B = 3'd2;
    localparam logic [2:0] R8_C = 3'd3;
    localparam logic [2:0] R8_D = 3'd4;
    localparam logic [2:0] R8_E = 3'd5;
    localparam logic [2:0] R8_H = 3'd6;
    localparam logic [2:0] R8_L = 3'd7;

    localparam logic [2:0] R16_WZ = 3'd0;
    localparam logic [2:0] R16_BC = 3'd1;
    localparam logic [2:0] R16_DE = 3'd2;
    localparam logic [2:0] R16_HL = 3'd3;
    localparam logic [2:0] R16_SP = 3'd4;
    localparam logic [2:0] R16_PC = 3'd5;

    function automatic logic is_op16(input op_e op);
        return op == OP_RD16 || op == OP_WR16;
    endfunction

    function automatic logic sel16_legal(input logic [2:0] sel);
        return sel <= R16_PC;
    endfunction

    function automatic logic [7:0] strobe8(input logic [2:0] sel);
        return 8'b1 << sel;
    endfunction

    function automatic logic [5:0] strobe16(input logic [2:0] sel);
        return sel16_legal(sel) ? (6'b1 << sel) : 6'b0;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin pick: first requester strictly after the pointer, wrapping,
// returned as a one-hot grant plus its index.
module rr_priority_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] id_o
);

    int idx;

    // Walk from the farthest slot back to the nearest so the nearest wins.
    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        idx   = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_i) + k) % N;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                id_o       = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter sharing the CPU register file between requesters.
// Optional grant locking for atomic sequences: define REGARB_LOCK_EN.
module reg_file_arbiter
    import regarb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_n,
    input  logic                    i_Enable,
    input  logic [NUM_REQ-1:0]      i_Req_Valid,
    output logic [NUM_REQ-1:0]      o_Req_Ready,
    input  logic [2*NUM_REQ-1:0]    i_Req_Op,
    input  logic [3*NUM_REQ-1:0]    i_Req_Sel,
    input  logic [16*NUM_REQ-1:0]   i_Req_Data,
    input  logic [NUM_REQ-1:0]      i_Req_Lock,
    output logic [7:0]              o_Read8,
    output logic [7:0]              o_Write8,
    output logic [5:0]              o_Read16,
    output logic [5:0]              o_Write16,
    output logic [7:0]              o_Bus8,
    input  logic [7:0]              i_Bus8,
    output logic [15:0]             o_Bus16,
    input  logic [15:0]             i_Bus16,
    output logic [NUM_REQ-1:0]      o_Rsp_Valid,
    output logic [15:0]             o_Rsp_Data,
    output logic                    o_Rsp_Err
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_id;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               accept;

    rr_priority_picker #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req_i (i_Req_Valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .id_o  (pick_id)
    );

`ifdef REGARB_LOCK_EN
    logic            lock_q;
    logic [ID_W-1:0] lock_id_q;
    logic            lock_hold;

    assign lock_hold = lock_q && i_Req_Valid[lock_id_q];

    always_comb begin
        gnt    = pick_gnt;
        gnt_id = pick_id;
        if (lock_hold) begin
            gnt            = '0;
            gnt[lock_id_q] = 1'b1;
            gnt_id         = lock_id_q;
        end
    end

    // Lock drops on an unlocked accept or when the holder withdraws valid.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (i_Enable) begin
            if (accept) begin
                lock_q    <= i_Req_Lock[gnt_id];
                lock_id_q <= gnt_id;
            end else if (lock_q && !lock_hold) begin
                lock_q <= 1'b0;
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^i_Req_Lock;
    assign gnt    = pick_gnt;
    assign gnt_id = pick_id;
`endif

    assign o_Req_Ready = i_Enable ? gnt : '0;
    assign accept      = |o_Req_Ready;

    op_e         a_op;
    logic [2:0]  a_sel;
    logic [15:0] a_data;
    logic        a_err;

    assign a_op   = op_e'(i_Req_Op[int'(gnt_id)*2 +: 2]);
    assign a_sel  = i_Req_Sel[int'(gnt_id)*3 +: 3];
    assign a_data = i_Req_Data[int'(gnt_id)*16 +: 16];
    assign a_err  = is_op16(a_op) && !sel16_legal(a_sel);

    logic            b_valid_q, b_valid_d;
    logic [ID_W-1:0] b_id_q, b_id_d;
    op_e             b_op_q, b_op_d;
    logic            b_err_q, b_err_d;
    logic [7:0]      r8_q, r8_d, w8_q, w8_d, bus8_q, bus8_d;
    logic [5:0]      r16_q, r16_d, w16_q, w16_d;
    logic [15:0]     bus16_q, bus16_d;

    always_comb begin
        b_valid_d = accept;
        b_id_d    = gnt_id;
        b_op_d    = a_op;
        b_err_d   = accept && a_err;
        r8_d      = '0;
        w8_d      = '0;
        r16_d     = '0;
        w16_d     = '0;
        bus8_d    = '0;
        bus16_d   = '0;
        if (accept) begin
            unique case (a_op)
                OP_RD8:  r8_d = strobe8(a_sel);
                OP_WR8: begin
                    w8_d   = strobe8(a_sel);
                    bus8_d = a_data[7:0];
                end
                OP_RD16: r16_d = strobe16(a_sel);
                OP_WR16: begin
                    w16_d   = strobe16(a_sel);
                    bus16_d = a_err ? 16'h0 : a_data;
                end
            endcase
        end
    end

    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [15:0]        rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    // Read data is sampled off the file buses while stage B strobes are live.
    always_comb begin
        rsp_valid_d         = '0;
        rsp_valid_d[b_id_q] = b_valid_q;
        rsp_err_d           = b_valid_q && b_err_q;
        rsp_data_d          = '0;
        if (b_valid_q && !b_err_q) begin
            if (b_op_q == OP_RD8) rsp_data_d = {8'h00, i_Bus8};
            if (b_op_q == OP_RD16) rsp_data_d = i_Bus16;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            b_valid_q   <= 1'b0;
            b_id_q      <= '0;
            b_op_q      <= OP_RD8;
            b_err_q     <= 1'b0;
            r8_q        <= '0;
            w8_q        <= '0;
            r16_q       <= '0;
            w16_q       <= '0;
            bus8_q      <= '0;
            bus16_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else if (i_Enable) begin
            if (accept) ptr_q <= gnt_id;
            b_valid_q   <= b_valid_d;
            b_id_q      <= b_id_d;
            b_op_q      <= b_op_d;
            b_err_q     <= b_err_d;
            r8_q        <= r8_d;
            w8_q        <= w8_d;
            r16_q       <= r16_d;
            w16_q       <= w16_d;
            bus8_q      <= bus8_d;
            bus16_q     <= bus16_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_Read8     = r8_q;
    assign o_Write8    = w8_q;
    assign o_Read16    = r16_q;
    assign o_Write16   = w16_q;
    assign o_Bus8      = bus8_q;
    assign o_Bus16     = bus16_q;
    assign o_Rsp_Valid = rsp_valid_q;
    assign o_Rsp_Data  = rsp_data_q;
    assign o_Rsp_Err   = rsp_err_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Scoreboard bench for reg_file_arbiter with a behavioural register file.
// Grant-order expectations follow REGARB_LOCK_EN when it is defined.
module tb_reg_file_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [2:0]  vld = '0;
    logic [2:0]  rdy;
    logic [5:0]  req_op = '0;
    logic [8:0]  req_sel = '0;
    logic [47:0] req_dat = '0;
    logic [2:0]  req_lck = '0;
    logic [7:0]  r8, w8, b8o, b8i;
    logic [5:0]  r16, w16;
    logic [15:0] b16o, b16i;
    logic [2:0]  rsp_v;
    logic [15:0] rsp_d;
    logic        rsp_e;

    reg_file_arbiter #(.NUM_REQ(3)) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Enable    (en),
        .i_Req_Valid (vld),
        .o_Req_Ready (rdy),
        .i_Req_Op    (req_op),
        .i_Req_Sel   (req_sel),
        .i_Req_Data  (req_dat),
        .i_Req_Lock  (req_lck),
        .o_Read8     (r8),
        .o_Write8    (w8),
        .o_Read16    (r16),
        .o_Write16   (w16),
        .o_Bus8      (b8o),
        .i_Bus8      (b8i),
        .o_Bus16     (b16o),
        .i_Bus16     (b16i),
        .o_Rsp_Valid (rsp_v),
        .o_Rsp_Data  (rsp_d),
        .o_Rsp_Err   (rsp_e)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Behavioural register file driven by the DUT strobes.
    logic [7:0]  f8 [8];
    logic [15:0] fsp, fpc;

    initial begin
        for (int i = 0; i < 8; i++) f8[i] = 8'h00;
        fsp = 16'h0;
        fpc = 16'h0;
    end

    always @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 8; i++)
                if (w8[i]) f8[i] <= b8o;
            for (int k = 0; k < 4; k++)
                if (w16[k]) begin
                    f8[2*k]   <= b16o[15:8];
                    f8[2*k+1] <= b16o[7:0];
                end
            if (w16[4]) fsp <= b16o;
            if (w16[5]) fpc <= b16o;
        end
    end

    always_comb begin
        b8i  = 8'h00;
        b16i = 16'h0;
        for (int i = 0; i < 8; i++)
            if (r8[i]) b8i = b8i | f8[i];
        for (int k = 0; k < 4; k++)
            if (r16[k]) b16i = b16i | {f8[2*k], f8[2*k+1]};
        if (r16[4]) b16i = b16i | fsp;
        if (r16[5]) b16i = b16i | fpc;
    end

    // Architectural model updated in acceptance order.
    logic [7:0]  m8 [8];
    logic [15:0] msp, mpc;

    initial begin
        for (int i = 0; i < 8; i++) m8[i] = 8'h00;
        msp = 16'h0;
        mpc = 16'h0;
    end

    typedef struct {
        int          t;
        logic [7:0]  r8, w8, b8;
        logic [5:0]  r16, w16;
        logic [15:0] b16;
    } sexp_t;

    typedef struct {
        int          t;
        logic [2:0]  v;
        logic [15:0] d;
        logic        e;
    } rexp_t;

    sexp_t sq[$];
    rexp_t rq[$];
    int    glog[$];
    int    tcnt = 0;
    int    last_t = 0;
    logic [2:0]  last_rv = '0;
    logic [15:0] last_rsp = '0;

    always @(posedge clk) if (rst_n && en) tcnt <= tcnt + 1;

    always @(negedge clk) begin : mon
        sexp_t se;
        rexp_t re;
        sexp_t sp;
        rexp_t rp;
        int    id;
        logic [1:0]  op;
        logic [2:0]  sel;
        logic [15:0] d;
        if (!en) check("stall_rdy", 32'(rdy), 32'h0);
        check("rdy_subset", 32'(rdy & ~vld), 32'h0);
        if (tcnt != last_t) begin
            if (sq.size() > 0 && sq[0].t == tcnt) begin
                sp = sq.pop_front();
                check("read8", 32'(r8), 32'(sp.r8));
                check("write8", 32'(w8), 32'(sp.w8));
                check("read16", 32'(r16), 32'(sp.r16));
                check("write16", 32'(w16), 32'(sp.w16));
                check("bus8", 32'(b8o), 32'(sp.b8));
                check("bus16", 32'(b16o), 32'(sp.b16));
            end else begin
                check("strobe_idle", {6'h0, r8, w8, r16, w16}, 32'h0);
            end
            if (rq.size() > 0 && rq[0].t == tcnt) begin
                rp = rq.pop_front();
                check("rsp_valid", 32'(rsp_v), 32'(rp.v));
                check("rsp_data", 32'(rsp_d), 32'(rp.d));
                check("rsp_err", 32'(rsp_e), 32'(rp.e));
                last_rsp <= rsp_d;
            end else begin
                check("rsp_idle", 32'(rsp_v), 32'h0);
            end
        end else begin
            check("rsp_hold", 32'(rsp_v), 32'(last_rv));
        end
        last_t  <= tcnt;
        last_rv <= rsp_v;
        if (en && |(rdy & vld)) begin
            id = 0;
            for (int i = 0; i < 3; i++) if (rdy[i] && vld[i]) id = i;
            op  = req_op[id*2 +: 2];
            sel = req_sel[id*3 +: 3];
            d   = req_dat[id*16 +: 16];
            se  = '{t: tcnt + 1, r8: 8'h0, w8: 8'h0, b8: 8'h0,
                    r16: 6'h0, w16: 6'h0, b16: 16'h0};
            re  = '{t: tcnt + 2, v: 3'b001 << id, d: 16'h0, e: 1'b0};
            case (op)
                2'b00: begin
                    se.r8 = 8'b1 << sel;
                    re.d  = {8'h00, m8[sel]};
                end
                2'b01: begin
                    se.w8 = 8'b1 << sel;
                    se.b8 = d[7:0];
                    m8[sel] <= d[7:0];
                end
                2'b10: begin
                    if (sel > 3'd5) re.e = 1'b1;
                    else begin
                        se.r16 = 6'b1 << sel;
                        if (sel < 3'd4) re.d = {m8[2*sel], m8[2*sel+1]};
                        else if (sel == 3'd4) re.d = msp;
                        else re.d = mpc;
                    end
                end
                default: begin
                    if (sel > 3'd5) re.e = 1'b1;
                    else begin
                        se.w16 = 6'b1 << sel;
                        se.b16 = d;
                        if (sel < 3'd4) begin
                            m8[2*sel]   <= d[15:8];
                            m8[2*sel+1] <= d[7:0];
                        end else if (sel == 3'd4) msp <= d;
                        else mpc <= d;
                    end
                end
            endcase
            sq.push_back(se);
            rq.push_back(re);
            glog.push_back(id);
        end
    end

    task automatic set_cmd(input int id, input logic [1:0] op,
                           input logic [2:0] sel, input logic [15:0] d);
        req_op[id*2 +: 2]   = op;
        req_sel[id*3 +: 3]  = sel;
        req_dat[id*16 +: 16] = d;
    endtask

    task automatic issue(input int id, input logic [1:0] op,
                         input logic [2:0] sel, input logic [15:0] d);
        bit done;
        done = 1'b0;
        set_cmd(id, op, sel, d);
        vld[id] = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (en && rdy[id]) done = 1'b1;
            @(posedge clk);
            #1;
        end
        vld[id] = 1'b0;
        if (!done) check("issue_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_grants(input int target);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(posedge clk);
            #1;
            if (glog.size() >= target) done = 1'b1;
        end
        if (!done) check("grant_timeout", 32'h0, 32'h1);
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int s;
    int n1;
    bit a1;
    int exp6 [5];

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdy", 32'(rdy), 32'h0);
        check("reset_strobe", {6'h0, r8, w8, r16, w16}, 32'h0);
        check("reset_bus", {b8o, b16o}, 32'h0);
        check("reset_rsp", {rsp_v, rsp_e, rsp_d}, 32'h0);
        rst_n = 1'b1;

        // Write pair BC, then read C back zero-extended.
        issue(0, 2'b11, 3'd1, 16'h1234);
        issue(0, 2'b00, 3'd3, 16'h0000);
        drain();
        check("t1_rd_c", 32'(last_rsp), 32'h0034);

        // Continuous contention: strict rotation from requester 0.
        reset_dut();
        s = glog.size();
        for (int i = 0; i < 3; i++) set_cmd(i, 2'b10, 3'd5, 16'h0);
        vld = 3'b111;
        wait_grants(s + 6);
        vld = 3'b000;
        drain();
        for (int i = 0; i < 6; i++)
            check("t2_grant", 32'(glog[s+i]), 32'(i % 3));

        // Half write visible to an immediately following pair read.
        issue(2, 2'b01, 3'd7, 16'h00CD);
        issue(1, 2'b01, 3'd6, 16'h00AB);
        issue(1, 2'b10, 3'd3, 16'h0000);
        drain();
        check("t3_hl", 32'(last_rsp), 32'hABCD);

        // Illegal 16-bit select, then a normal read.
        issue(0, 2'b10, 3'd7, 16'h0000);
        issue(0, 2'b11, 3'd4, 16'hBEEF);
        issue(0, 2'b10, 3'd4, 16'h0000);
        drain();
        check("t4_sp", 32'(last_rsp), 32'hBEEF);

        // Stall in the middle of a contended stream.
        s = glog.size();
        set_cmd(0, 2'b00, 3'd6, 16'h0);
        set_cmd(1, 2'b00, 3'd7, 16'h0);
        set_cmd(2, 2'b10, 3'd1, 16'h0);
        vld = 3'b111;
        wait_grants(s + 2);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        wait_grants(s + 6);
        vld = 3'b000;
        drain();
        check("t5_count", 32'(glog.size() - s), 32'd6);

        // Locked sequence from requester 1 against two competitors.
        reset_dut();
        issue(0, 2'b00, 3'd0, 16'h0);
        drain();
        s = glog.size();
        n1 = 0;
        set_cmd(0, 2'b10, 3'd5, 16'h0);
        set_cmd(2, 2'b10, 3'd5, 16'h0);
        set_cmd(1, 2'b11, 3'd4, 16'h1000);
        req_lck = 3'b010;
        vld = 3'b111;
        for (int n = 0; n < 40 && glog.size() < s + 5; n++) begin
            @(negedge clk);
            a1 = en && rdy[1];
            @(posedge clk);
            #1;
            if (a1) begin
                n1++;
                if (n1 >= 4) vld[1] = 1'b0;
                else begin
                    set_cmd(1, 2'b11, 3'd4, 16'h1000 + 16'(n1));
                    req_lck[1] = (n1 < 3);
                end
            end
        end
        vld = 3'b000;
        req_lck = 3'b000;
        drain();
`ifdef REGARB_LOCK_EN
        exp6 = '{1, 1, 1, 1, 2};
`else
        exp6 = '{1, 2, 0, 1, 2};
`endif
        check("t6_count", 32'(glog.size() >= s + 5), 32'h1);
        for (int i = 0; i < 5; i++)
            if (glog.size() > s + i)
                check("t6_grant", 32'(glog[s+i]), 32'(exp6[i]));

        check("sq_empty", 32'(sq.size()), 32'h0);
        check("rq_empty", 32'(rq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
